// File: rtl/wb_eth_regbd_slave.sv
// Wishbone classic slave for the Ethernet MAC host side: control/status register
// file, buffer-descriptor RAM and interrupt source/mask logic with a registered response.
module wb_eth_regbd_slave #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          NUM_REGS   = 21,
  parameter int          BD_WORDS   = 256,
  parameter logic [31:0] MODER_RST  = 32'h0000_A000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  input  logic [6:0]              irq_src_i,
  output logic                    int_o,
  output logic [DATA_WIDTH-1:0]   moder_o
);

  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int BD_AW  = $clog2(BD_WORDS);
  localparam int IRQ_W  = 7;
  localparam logic [ADDR_WIDTH-1:0] BD_BASE = ADDR_WIDTH'(256);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic   latch_en, commit;

  logic [ADDR_WIDTH-1:0] adr_p0;
  logic [DATA_WIDTH-1:0] dat_p0;
  logic [SEL_W-1:0]      sel_p0;
  logic                  we_p0;

  logic                  reg_hit, bd_hit, acc_err, wr_reg, wr_bd;
  logic [REG_AW-1:0]     reg_idx;
  logic [BD_AW-1:0]      bd_idx;
  logic [IRQ_W-1:0]      int_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] bd_mem [BD_WORDS];

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: if (wb_cyc_i && wb_stb_i) begin
        latch_en = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (!wb_cyc_i) begin
        state_d = IDLE;
      end else begin
        commit  = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request stage p0: address/data/lanes held for the WAIT cycle
  always_ff @(posedge wb_clk_i) begin
    if (latch_en) begin
      adr_p0 <= wb_adr_i;
      dat_p0 <= wb_dat_i;
      sel_p0 <= wb_sel_i;
      we_p0  <= wb_we_i;
    end
  end

  // Registers need a full word; BD words only need at least one lane
  assign reg_hit = adr_p0 < ADDR_WIDTH'(NUM_REGS);
  assign bd_hit  = (adr_p0 >= BD_BASE) && (adr_p0 < BD_BASE + ADDR_WIDTH'(BD_WORDS));
  assign acc_err = !((reg_hit && (&sel_p0)) || (bd_hit && (|sel_p0)));
  assign reg_idx = adr_p0[REG_AW-1:0];
  assign bd_idx  = adr_p0[BD_AW-1:0];
  assign wr_reg  = commit && we_p0 && !acc_err && reg_hit;
  assign wr_bd   = commit && we_p0 && !acc_err && bd_hit;
  assign int_clr = (wr_reg && reg_idx == REG_AW'(1)) ? dat_p0[IRQ_W-1:0] : '0;
  assign rd_data = reg_hit ? regs[reg_idx] : bd_mem[bd_idx];

  // Response stage: one-cycle ack/err with read data, zero otherwise
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      wb_ack_o <= commit && !acc_err;
      wb_err_o <= commit && acc_err;
      wb_dat_o <= (commit && !acc_err && !we_p0) ? rd_data : '0;
    end
  end

  // Interrupt sources set by MAC pulses; a same-cycle host clear loses to a new event
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[0] <= MODER_RST;
      int_o   <= 1'b0;
    end else begin
      regs[1] <= {{(DATA_WIDTH-IRQ_W){1'b0}}, (regs[1][IRQ_W-1:0] & ~int_clr) | irq_src_i};
      if (wr_reg && reg_idx != REG_AW'(1)) begin
        if (reg_idx == REG_AW'(2)) regs[2] <= {{(DATA_WIDTH-IRQ_W){1'b0}}, dat_p0[IRQ_W-1:0]};
        else                       regs[reg_idx] <= dat_p0;
      end
      int_o <= |(regs[1][IRQ_W-1:0] & regs[2][IRQ_W-1:0]);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_bd) begin
      for (int b = 0; b < SEL_W; b++)
        if (sel_p0[b]) bd_mem[bd_idx][b*8 +: 8] <= dat_p0[b*8 +: 8];
    end
  end

  assign moder_o = regs[0];

endmodule

// File: tb/tb_wb_eth_regbd_slave.sv
// Self-checking bench for wb_eth_regbd_slave: directed scenarios plus randomized
// accesses compared against an address-map level model of the register/BD space.
module tb_wb_eth_regbd_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  wb_adr;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [6:0]  irq_src;
  logic        int_o;
  logic [31:0] moder_o;

  always #5 clk = ~clk;

  wb_eth_regbd_slave dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .wb_adr_i (wb_adr),   .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel),   .wb_we_i  (wb_we),
    .wb_cyc_i (wb_cyc),   .wb_stb_i (wb_stb),
    .wb_dat_o (wb_dat_o), .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o), .irq_src_i(irq_src),
    .int_o    (int_o),    .moder_o  (moder_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model of the address space
  logic [31:0] m_reg [0:20];
  logic [6:0]  m_isrc, m_imask;
  logic [31:0] m_bd  [0:255];
  logic [3:0]  m_bd_bv [0:255];

  function automatic bit exp_err(input logic [9:0] a, input logic [3:0] s);
    int ai = int'(a);
    if (ai < 21) return s != 4'hF;
    if (ai >= 256 && ai < 512) return s == 4'h0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [9:0] a);
    int ai = int'(a);
    if (ai == 1) return {25'b0, m_isrc};
    if (ai == 2) return {25'b0, m_imask};
    if (ai < 21) return m_reg[ai];
    return m_bd[ai-256];
  endfunction

  function automatic bit known(input logic [9:0] a);
    int ai = int'(a);
    if (ai < 21) return 1'b1;
    return m_bd_bv[ai-256] == 4'hF;
  endfunction

  function automatic logic exp_int();
    return |(m_isrc & m_imask);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 21; i++) m_reg[i] = 32'h0;
    m_reg[0] = 32'h0000_A000;
    m_isrc   = 7'h0;
    m_imask  = 7'h0;
  endtask

  task automatic model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    int ai = int'(a);
    if (exp_err(a, s)) return;
    if (ai == 1)       m_isrc = m_isrc & ~d[6:0];
    else if (ai == 2)  m_imask = d[6:0];
    else if (ai < 21)  m_reg[ai] = d;
    else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_bd[ai-256][b*8 +: 8] = d[b*8 +: 8];
      m_bd_bv[ai-256] = m_bd_bv[ai-256] | s;
    end
  endtask

  // Bus driver: returns termination, latency in edges, and whether ack/err persisted a cycle
  task automatic wb_access(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic we, output logic [31:0] rdat, output logic ack,
                           output logic err, output int lat, output logic tail);
    wb_adr = a; wb_dat_i = d; wb_sel = s; wb_we = we;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    ack = 1'b0; err = 1'b0; rdat = 32'h0; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) begin
        ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o; lat = c;
        break;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    tail = wb_ack_o | wb_err_o;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ack, err, tail; int lat;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || int_o !== 1'b0 || wb_dat_o !== 32'h0 || moder_o !== 32'h0000_A000) begin
      miscompares++;
      $display("FAIL reset_state: ack=%b err=%b int=%b dat=%h moder=%h, want 0 0 0 00000000 0000a000",
               wb_ack_o, wb_err_o, int_o, wb_dat_o, moder_o);
    end
    rst = 1'b0;
    model_reset();
    wb_access(10'd0, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0 || lat != 2 || tail !== 1'b0 || rd !== 32'h0000_A000) begin
      miscompares++;
      $display("FAIL read_moder: ack=%b err=%b lat=%0d tail=%b dat=%h, want 1 0 2 0 0000a000", ack, err, lat, tail, rd);
    end
    wb_access(10'd5, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL read_word5: ack=%b err=%b dat=%h, want 1 0 00000000", ack, err, rd);
    end
  endtask

  task automatic test_bd_bytes();
    logic [31:0] rd; logic ack, err, tail; int lat;
    wb_access(10'd256, 32'hDEAD_BEEF, 4'hF, 1'b1, rd, ack, err, lat, tail);
    model_write(10'd256, 32'hDEAD_BEEF, 4'hF);
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0 || lat != 2 || tail !== 1'b0) begin
      miscompares++;
      $display("FAIL bd_write_full: ack=%b err=%b lat=%0d tail=%b, want 1 0 2 0", ack, err, lat, tail);
    end
    wb_access(10'd256, 32'h0000_0011, 4'b0001, 1'b1, rd, ack, err, lat, tail);
    model_write(10'd256, 32'h0000_0011, 4'b0001);
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL bd_write_byte: ack=%b err=%b, want 1 0", ack, err);
    end
    wb_access(10'd256, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 32'hDEAD_BE11) begin
      miscompares++;
      $display("FAIL bd_readback: ack=%b err=%b dat=%h, want 1 0 deadbe11", ack, err, rd);
    end
  endtask

  task automatic test_err();
    logic [31:0] rd; logic ack, err, tail; int lat;
    logic [9:0] badr [8];
    logic [3:0] bsel [8];
    badr = '{10'd20, 10'd21, 10'd255, 10'd256, 10'd511, 10'd512, 10'd1023, 10'd300};
    bsel = '{4'hF,   4'hF,   4'hF,    4'h8,    4'hF,    4'hF,    4'hF,     4'h0};
    wb_access(10'd3, 32'h1234_5678, 4'h3, 1'b1, rd, ack, err, lat, tail);
    model_write(10'd3, 32'h1234_5678, 4'h3);
    vectors++;
    if (ack !== 1'b0 || err !== 1'b1 || lat != 2 || tail !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_partial_sel: ack=%b err=%b lat=%0d tail=%b, want 0 1 2 0", ack, err, lat, tail);
    end
    wb_access(10'd3, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || rd !== exp_read(10'd3)) begin
      miscompares++;
      $display("FAIL reg3_unchanged: ack=%b dat=%h, want 1 %h", ack, rd, exp_read(10'd3));
    end
    wb_access(10'd600, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b0 || err !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL read_600: ack=%b err=%b dat=%h, want 0 1 00000000", ack, err, rd);
    end
    wb_access(10'd511, 32'hA5A5_0F0F, 4'hF, 1'b1, rd, ack, err, lat, tail);
    model_write(10'd511, 32'hA5A5_0F0F, 4'hF);
    for (int i = 0; i < 8; i++) begin
      logic e;
      e = exp_err(badr[i], bsel[i]);
      wb_access(badr[i], 32'h0, bsel[i], 1'b0, rd, ack, err, lat, tail);
      vectors++;
      if (ack !== !e || err !== e || (e && rd !== 32'h0) || (!e && known(badr[i]) && rd !== exp_read(badr[i]))) begin
        miscompares++;
        $display("FAIL boundary_%0d: adr=%0d sel=%h ack=%b err=%b dat=%h, want ack=%b err=%b",
                 i, badr[i], bsel[i], ack, err, rd, !e, e);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic ack, err, tail; int lat;
    wb_access(10'd2, 32'h0000_0005, 4'hF, 1'b1, rd, ack, err, lat, tail);
    model_write(10'd2, 32'h0000_0005, 4'hF);
    irq_src = 7'h04;
    @(posedge clk); #1;
    irq_src = 7'h00;
    m_isrc = m_isrc | 7'h04;
    vectors++;
    if (int_o !== 1'b0) begin
      miscompares++;
      $display("FAIL int_early: int_o=%b, want 0", int_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (int_o !== 1'b1) begin
      miscompares++;
      $display("FAIL int_raise: int_o=%b, want 1", int_o);
    end
    // host clear of bit 2 commits on the same edge as a fresh bit-2 event
    wb_adr = 10'd1; wb_dat_i = 32'h4; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    irq_src = 7'h04;
    @(posedge clk); #1;
    irq_src = 7'h00;
    m_isrc = (m_isrc & ~7'h04) | 7'h04;
    vectors++;
    if (wb_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_set_ack: ack=%b, want 1", wb_ack_o);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    wb_access(10'd1, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (rd !== exp_read(10'd1) || int_o !== 1'b1) begin
      miscompares++;
      $display("FAIL set_wins: src=%h int=%b, want %h 1", rd, int_o, exp_read(10'd1));
    end
    irq_src = 7'h02;
    @(posedge clk); #1;
    irq_src = 7'h00;
    m_isrc = m_isrc | 7'h02;
    wb_access(10'd1, 32'h0000_0004, 4'hF, 1'b1, rd, ack, err, lat, tail);
    model_write(10'd1, 32'h0000_0004, 4'hF);
    vectors++;
    if (int_o !== 1'b0) begin
      miscompares++;
      $display("FAIL int_clear: int_o=%b, want 0", int_o);
    end
    wb_access(10'd1, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (rd !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL src_after_clear: src=%h, want 00000002", rd);
    end
    for (int i = 0; i < 10; i++) begin
      logic [31:0] d;
      d = $urandom;
      wb_access(10'd2, d, 4'hF, 1'b1, rd, ack, err, lat, tail);
      model_write(10'd2, d, 4'hF);
      irq_src = 7'($urandom);
      m_isrc = m_isrc | irq_src;
      @(posedge clk); #1;
      irq_src = 7'h00;
      @(posedge clk); #1;
      vectors++;
      if (int_o !== exp_int()) begin
        miscompares++;
        $display("FAIL int_rand_%0d: int_o=%b, want %b (src=%h mask=%h)", i, int_o, exp_int(), m_isrc, m_imask);
      end
      if (i % 3 == 2) begin
        d = $urandom;
        wb_access(10'd1, d, 4'hF, 1'b1, rd, ack, err, lat, tail);
        model_write(10'd1, d, 4'hF);
        vectors++;
        if (int_o !== exp_int()) begin
          miscompares++;
          $display("FAIL int_rclr_%0d: int_o=%b, want %b", i, int_o, exp_int());
        end
      end
    end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; logic ack, err, tail; int lat; int seen;
    wb_adr = 10'd4; wb_dat_i = 32'hCAFE_F00D; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wb_ack_o || wb_err_o) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_resp: responses=%0d, want 0", seen);
    end
    wb_access(10'd4, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || rd !== exp_read(10'd4)) begin
      miscompares++;
      $display("FAIL abort_no_write: ack=%b dat=%h, want 1 %h", ack, rd, exp_read(10'd4));
    end
    wb_adr = 10'd0; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (wb_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_before_rst: ack=%b, want 1", wb_ack_o);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    vectors++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_in_resp: ack=%b err=%b dat=%h, want 0 0 00000000", wb_ack_o, wb_err_o, wb_dat_o);
    end
    @(posedge clk); #1;
    wb_access(10'd0, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || lat != 2 || rd !== 32'h0000_A000) begin
      miscompares++;
      $display("FAIL read_after_rst: ack=%b lat=%0d dat=%h, want 1 2 0000a000", ack, lat, rd);
    end
    wb_adr = 10'd3; wb_dat_i = 32'h7777_7777; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    vectors++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_wait: ack=%b err=%b, want 0 0", wb_ack_o, wb_err_o);
    end
    @(posedge clk); #1;
    wb_access(10'd3, 32'h0, 4'hF, 1'b0, rd, ack, err, lat, tail);
    vectors++;
    if (ack !== 1'b1 || rd !== exp_read(10'd3)) begin
      miscompares++;
      $display("FAIL write_dropped: ack=%b dat=%h, want 1 %h", ack, rd, exp_read(10'd3));
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] got, want;
    wb_adr = 10'd0; wb_sel = 4'hF; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    got = '0; want = '0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      got[c-1]  = wb_ack_o && (wb_dat_o === m_reg[0]);
      want[c-1] = (c % 3) == 2;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL back_to_back: ack pattern=%b, want %b", got, want);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic ack, err, tail, we, e; int lat; logic [9:0] a; logic [3:0] s;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 10'($urandom_range(0, 24));
        1:       a = 10'($urandom_range(250, 520));
        default: a = 10'($urandom_range(0, 1023));
      endcase
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      we = 1'($urandom);
      d  = $urandom;
      e  = exp_err(a, s);
      wb_access(a, d, s, we, rd, ack, err, lat, tail);
      vectors++;
      if (ack !== !e || err !== e || lat != 2 || tail !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_hs_%0d: adr=%0d sel=%h we=%b ack=%b err=%b lat=%0d tail=%b, want ack=%b err=%b lat=2",
                 i, a, s, we, ack, err, lat, tail, !e, e);
      end
      if (!we) begin
        if (e || known(a)) begin
          vectors++;
          if (rd !== (e ? 32'h0 : exp_read(a))) begin
            miscompares++;
            $display("FAIL rand_rd_%0d: adr=%0d dat=%h, want %h", i, a, rd, e ? 32'h0 : exp_read(a));
          end
        end
      end else begin
        model_write(a, d, s);
      end
      vectors++;
      if (int_o !== exp_int()) begin
        miscompares++;
        $display("FAIL rand_int_%0d: int_o=%b, want %b", i, int_o, exp_int());
      end
    end
    vectors++;
    if (moder_o !== m_reg[0]) begin
      miscompares++;
      $display("FAIL moder_out: moder=%h, want %h", moder_o, m_reg[0]);
    end
  endtask

  initial begin
    rst = 1'b1; wb_adr = '0; wb_dat_i = '0; wb_sel = '0; wb_we = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; irq_src = '0;
    for (int i = 0; i < 256; i++) begin
      m_bd[i] = 32'h0;
      m_bd_bv[i] = 4'h0;
    end
    model_reset();
    test_reset();
    test_err();
    test_bd_bytes();
    test_irq();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_eth_regbd_slave.md
# wb_eth_regbd_slave

Synthesizable Wishbone classic slave that terminates the host-side register/buffer-descriptor cycles issued by the Wishbone master driver in the Ethernet MAC environment. It decodes the 10-bit word address into a control/status register file and a 256-word buffer-descriptor RAM, and returns ack or err with registered read data. It also owns the interrupt source/mask logic and raises `int_o`.

## Interface
- `DATA_WIDTH`, 32, Wishbone data width (fixed 32; sel is DATA_WIDTH/8).
- `ADDR_WIDTH`, 10, word address width (byte address bits [11:2]).
- `NUM_REGS`, 21, implemented register words at word addresses 0..NUM_REGS-1.
- `BD_WORDS`, 256, buffer-descriptor words at word addresses 256..511.
- `MODER_RST`, 32'h0000_A000, reset value of register word 0 (MODER).

- `wb_clk_i` in 1 — single clock; all state updates on rising edge.
- `wb_rst_i` in 1 — reset, synchronous and active-high.
- `wb_adr_i` in 10 — word address (byte address [11:2]).
- `wb_dat_i` in 32 — write data.
- `wb_sel_i` in 4 — byte lane enables.
- `wb_we_i` in 1 — 1 = write, 0 = read.
- `wb_cyc_i` in 1 — bus cycle valid.
- `wb_stb_i` in 1 — strobe.
- `wb_dat_o` out 32 — read data, valid only while `wb_ack_o`=1.
- `wb_ack_o` out 1 — normal termination, one-cycle pulse.
- `wb_err_o` out 1 — error termination, one-cycle pulse.
- `irq_src_i` in 7 — interrupt event pulses from MAC core, one bit per source.
- `int_o` out 1 — registered, OR of (INT_SOURCE & INT_MASK).
- `moder_o` out 32 — current MODER contents.

## Operation
- Address map (word addr): 0..NUM_REGS-1 registers; NUM_REGS..255 unmapped → err; 256..511 BD RAM; 512..1023 unmapped → err.
- Register access requires `wb_sel_i`=4'hF; any other sel → err, no write. BD access honours byte lanes; sel=4'h0 → err.
- Reads always return the full 32-bit word; unmapped/err cycles return `wb_dat_o`=0.
- Word 1 INT_SOURCE (bits [6:0], upper bits read 0): bit set by `irq_src_i` pulse; host write of 1 clears a bit, 0 leaves it. Same-cycle set and clear of one bit → set wins.
- Word 2 INT_MASK (bits [6:0]) plain R/W. All other registers plain R/W 32-bit.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on `wb_cyc_i & wb_stb_i` latch adr/dat/sel/we, decode → WAIT.
  - WAIT: if `wb_cyc_i`=0 → IDLE (cycle aborted, no write, no ack/err). Else commit write or read RAM/register, compute err → RESP with `wb_ack_o` or `wb_err_o` set (never both).
  - RESP: ack/err high this cycle only; → IDLE unconditionally.
- New request is not sampled in WAIT or RESP; master holding stb after ack starts a new access from IDLE.

## Timing
- Reset values: `wb_dat_o`=0, `wb_ack_o`=0, `wb_err_o`=0, `int_o`=0, `moder_o`=MODER_RST; INT_SOURCE=0, INT_MASK=0, other registers 0; FSM=IDLE. BD RAM contents not reset.
- Request sampled at edge k → write commits at edge k+1 → ack/err/dat_o high after edge k+1 for exactly one cycle → low after k+2.
- Minimum spacing: one access per 3 cycles with stb held continuously.
- `int_o` updates one cycle after INT_SOURCE/INT_MASK change; `moder_o` one cycle after write commit.
- Reset asserted in WAIT/RESP: pending write dropped, ack/err cleared on the same edge, FSM → IDLE.
- Read of register written by immediately preceding access returns new value.

## Test plan
- Reset then read word 0 → ack after 2 cycles, `wb_dat_o`=32'h0000_A000; read word 5 → 0.
- Write BD word 256 with 32'hDEAD_BEEF sel=4'hF, then write 32'h0000_0011 sel=4'b0001, read back → 32'hDEAD_BE11, ack each access, no err.
- Write register word 3 with sel=4'h3 → `wb_err_o` one cycle, `wb_ack_o`=0, readback unchanged 0; read word 600 → err, `wb_dat_o`=0.
- Set INT_MASK=7'h05, pulse `irq_src_i`=7'h04 → `int_o`=1 next cycle; write INT_SOURCE=7'h04 in same cycle as another irq_src_i[2] pulse → bit stays 1; later clear → `int_o`=0.
- Start write to word 4, drop `wb_cyc_i` in WAIT → no ack/err, word 4 still 0; assert `wb_rst_i` in RESP → ack low next cycle, FSM accepts a read two cycles later normally.
